// File: rtl/cmp_pkg.sv
// Shared definitions for compare_monitor: FSM state encoding, result-flag
// payload, counter widths and the gt_count saturation value.
package cmp_pkg;

  localparam int unsigned DATA_W   = 4;
  localparam int unsigned RUN_W    = 4;
  localparam int unsigned GT_CNT_W = 8;

  localparam logic [GT_CNT_W-1:0] GT_COUNT_MAX = 8'd255;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;  // no threshold loaded yet
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_ALARM = 2'd2;

  // Result flags; exactly one bit set while a result is valid, all zero otherwise
  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_flags_t;

  localparam cmp_flags_t FLAGS_NONE = '0;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
    return (v == '1) ? v : v + RUN_W'(1);
  endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude compare of a against b.
// Ports: sign (0 unsigned / 1 two's complement), a, b -> eq, gt, lt (one-hot).
module cmp_core
  import cmp_pkg::*;
(
  input  logic              sign,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              eq,
  output logic              gt,
  output logic              lt
);

  always_comb begin
    eq = (a == b);
    if (sign) begin
      gt = ($signed(a) > $signed(b));
    end else begin
      gt = (a > b);
    end
    lt = !eq && !gt;
  end

endmodule

// File: rtl/compare_monitor.sv
// Threshold compare monitor with valid/ready sample and result handshakes,
// a consecutive greater-than alarm and a saturating greater-than counter.
// Ports: clk, rst_n (async, active-low); sign; thr_load/thr_data (threshold);
//        in_valid/in_data/in_ready (samples); out_valid/out_ready (results);
//        equals/greater_than/less_than (result flags); alarm; gt_count.
// Build option: CMP_MON_HYST_EN -- leaving ALARM needs ALARM_COUNT consecutive
//        non-greater samples instead of one.
module compare_monitor
  import cmp_pkg::*;
#(
  parameter int unsigned ALARM_COUNT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sign,
  input  logic                thr_load,
  input  logic [DATA_W-1:0]   thr_data,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                equals,
  output logic                greater_than,
  output logic                less_than,
  output logic                alarm,
  output logic [GT_CNT_W-1:0] gt_count
);

  localparam logic [RUN_W-1:0] ALARM_CNT = RUN_W'(ALARM_COUNT);

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     thr_q, thr_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic                  out_valid_q, out_valid_d;
  cmp_flags_t            flags_q, flags_d;
  logic                  alarm_q, alarm_d;
  logic [GT_CNT_W-1:0]   gt_cnt_q, gt_cnt_d;
`ifdef CMP_MON_HYST_EN
  logic [RUN_W-1:0]      exit_q, exit_d;
`endif

  logic cmp_eq, cmp_gt, cmp_lt;
  logic accept;

  cmp_core u_cmp_core (
    .sign (sign),
    .a    (in_data),
    .b    (thr_q),
    .eq   (cmp_eq),
    .gt   (cmp_gt),
    .lt   (cmp_lt)
  );

  // Sample handshake: blocked before the first threshold, during a threshold
  // load, and while an unconsumed result is still pending.
  assign in_ready = (state_q != ST_IDLE) && !thr_load && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Next-state, result and counter logic
  always_comb begin
    state_d     = state_q;
    thr_d       = thr_q;
    run_d       = run_q;
    out_valid_d = out_valid_q;
    flags_d     = flags_q;
    gt_cnt_d    = gt_cnt_q;
`ifdef CMP_MON_HYST_EN
    exit_d      = exit_q;
`endif

    if (accept) begin
      out_valid_d = 1'b1;
      flags_d.eq  = cmp_eq;
      flags_d.gt  = cmp_gt;
      flags_d.lt  = cmp_lt;
      if (cmp_gt) begin
        run_d = sat_inc_run(run_q);
        if (gt_cnt_q != GT_COUNT_MAX) begin
          gt_cnt_d = gt_cnt_q + GT_CNT_W'(1);
        end
`ifdef CMP_MON_HYST_EN
        exit_d = '0;
`endif
        if ((state_q == ST_RUN) && (run_d >= ALARM_CNT)) begin
          state_d = ST_ALARM;
        end
      end else begin
        run_d = '0;
        if (state_q == ST_ALARM) begin
`ifdef CMP_MON_HYST_EN
          exit_d = sat_inc_run(exit_q);
          if (exit_d >= ALARM_CNT) begin
            state_d = ST_RUN;
            exit_d  = '0;
          end
`else
          state_d = ST_RUN;
`endif
        end
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      flags_d     = FLAGS_NONE;
    end

    // A threshold load never coincides with an accept (in_ready is low), and
    // leaves the result path above untouched.
    if (thr_load) begin
      thr_d   = thr_data;
      run_d   = '0;
      state_d = ST_RUN;
`ifdef CMP_MON_HYST_EN
      exit_d  = '0;
`endif
    end

    // Alarm is registered so it appears together with the result that caused it
    alarm_d = (state_d == ST_ALARM);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      thr_q       <= '0;
      run_q       <= '0;
      out_valid_q <= 1'b0;
      flags_q     <= FLAGS_NONE;
      alarm_q     <= 1'b0;
      gt_cnt_q    <= '0;
`ifdef CMP_MON_HYST_EN
      exit_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      thr_q       <= thr_d;
      run_q       <= run_d;
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
      alarm_q     <= alarm_d;
      gt_cnt_q    <= gt_cnt_d;
`ifdef CMP_MON_HYST_EN
      exit_q      <= exit_d;
`endif
    end
  end

  assign out_valid    = out_valid_q;
  assign equals       = flags_q.eq;
  assign greater_than = flags_q.gt;
  assign less_than    = flags_q.lt;
  assign alarm        = alarm_q;
  assign gt_count     = gt_cnt_q;

endmodule

// File: tb/tb_compare_monitor.sv
// Self-checking bench for compare_monitor: directed scenarios followed by a
// randomized phase, all checked against a cycle-level behavioural model.
module tb_compare_monitor;

  localparam int AC = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sign;
  logic       thr_load;
  logic [3:0] thr_data;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       equals;
  logic       greater_than;
  logic       less_than;
  logic       alarm;
  logic [7:0] gt_count;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  bit         m_armed;
  logic [3:0] m_thr;
  int         m_run;
  bit         m_alarm;
  int         m_gt_cnt;
  bit         m_ov;
  bit         m_eq, m_gt, m_lt;
`ifdef CMP_MON_HYST_EN
  int         m_exit;
`endif

  compare_monitor #(.ALARM_COUNT(AC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sign         (sign),
    .thr_load     (thr_load),
    .thr_data     (thr_data),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .equals       (equals),
    .greater_than (greater_than),
    .less_than    (less_than),
    .alarm        (alarm),
    .gt_count     (gt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sval(input logic [3:0] d, input bit sg);
    return (sg && d[3]) ? int'(d) - 16 : int'(d);
  endfunction

  task automatic model_reset();
    m_armed  = 1'b0;
    m_thr    = 4'd0;
    m_run    = 0;
    m_alarm  = 1'b0;
    m_gt_cnt = 0;
    m_ov     = 1'b0;
    m_eq     = 1'b0;
    m_gt     = 1'b0;
    m_lt     = 1'b0;
`ifdef CMP_MON_HYST_EN
    m_exit   = 0;
`endif
  endtask

  task automatic check_outputs();
    chk("out_valid",    32'(out_valid),    32'(m_ov));
    chk("equals",       32'(equals),       32'(m_eq));
    chk("greater_than", 32'(greater_than), 32'(m_gt));
    chk("less_than",    32'(less_than),    32'(m_lt));
    chk("alarm",        32'(alarm),        32'(m_alarm));
    chk("gt_count",     32'(gt_count),     32'(m_gt_cnt));
  endtask

  // One clock cycle: apply inputs, check in_ready, clock, advance model, check outputs
  task automatic step(input bit tl, input logic [3:0] td, input bit iv,
                      input logic [3:0] id, input bit sg, input bit ordy);
    bit rdy, acc;
    int a, b;
    thr_load  = tl;
    thr_data  = td;
    in_valid  = iv;
    in_data   = id;
    sign      = sg;
    out_ready = ordy;
    #1;
    rdy = m_armed && !tl && (!m_ov || ordy);
    acc = iv && rdy;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    @(posedge clk);
    if (acc) begin
      a = sval(id, sg);
      b = sval(m_thr, sg);
      m_ov = 1'b1;
      m_eq = (a == b);
      m_gt = (a > b);
      m_lt = (a < b);
      if (m_gt) begin
        if (m_run < 15) m_run++;
        if (m_gt_cnt < 255) m_gt_cnt++;
`ifdef CMP_MON_HYST_EN
        m_exit = 0;
`endif
        if (!m_alarm && m_run >= AC) m_alarm = 1'b1;
      end else begin
        m_run = 0;
        if (m_alarm) begin
`ifdef CMP_MON_HYST_EN
          m_exit++;
          if (m_exit >= AC) begin
            m_alarm = 1'b0;
            m_exit  = 0;
          end
`else
          m_alarm = 1'b0;
`endif
        end
      end
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
      m_eq = 1'b0;
      m_gt = 1'b0;
      m_lt = 1'b0;
    end
    if (tl) begin
      m_thr   = td;
      m_run   = 0;
      m_alarm = 1'b0;
      m_armed = 1'b1;
`ifdef CMP_MON_HYST_EN
      m_exit  = 0;
`endif
    end
    #1;
    check_outputs();
  endtask

  initial begin
    rst_n     = 1'b0;
    sign      = 1'b0;
    thr_load  = 1'b0;
    thr_data  = 4'd0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("reset_in_ready", 32'(in_ready), 32'(0));
    rst_n = 1'b1;

    // valid samples with no threshold are never taken
    for (int i = 0; i < 5; i++) step(1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 1'b1);
    chk("idle_no_out_valid", 32'(out_valid), 32'(0));

    // threshold 5, unsigned 8 is greater
    step(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b1, 4'd8, 1'b0, 1'b1);
    chk("unsigned_8_gt", 32'(greater_than), 32'(1));
    chk("unsigned_8_gt_count", 32'(gt_count), 32'(1));

    // signed 8 is -8, less than 5
    step(1'b0, 4'd0, 1'b1, 4'd8, 1'b1, 1'b1);
    chk("signed_8_lt", 32'(less_than), 32'(1));

    // three greater samples raise the alarm with the third result
    step(1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 1'b1);
    chk("alarm_not_yet", 32'(alarm), 32'(0));
    step(1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 1'b1);
    chk("alarm_third", 32'(alarm), 32'(1));
    step(1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 1'b1);
`ifdef CMP_MON_HYST_EN
    chk("alarm_after_low", 32'(alarm), 32'(1));
`else
    chk("alarm_after_low", 32'(alarm), 32'(0));
`endif

    // back-pressure: result held, no sample taken, then the stalled sample goes through
    step(1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b1, 4'd12, 1'b0, 1'b0);
    chk("stall_eq_held", 32'(equals), 32'(1));
    step(1'b0, 4'd0, 1'b1, 4'd12, 1'b0, 1'b1);
    chk("stall_sample_kept", 32'(greater_than), 32'(1));
    step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("drained", 32'(out_valid), 32'(0));

    // threshold reload while a result is pending
    step(1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0);
    step(1'b1, 4'd10, 1'b1, 4'd15, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd15, 1'b0, 1'b1);

    // gt_count saturation
    for (int i = 0; i < 300; i++) step(1'b0, 4'd0, 1'b1, 4'd14, 1'b0, 1'b1);
    chk("gt_count_sat", 32'(gt_count), 32'(255));

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end

    // asynchronous reset mid-run
    step(1'b0, 4'd0, 1'b1, 4'd15, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("async_rst_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1, 4'd7, 1'b0, 1'b1);
    step(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b1);
    chk("post_rst_eq", 32'(equals), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/compare_monitor.md
COMPARE_MONITOR -- requirements
Module: compare_monitor

Interface
REQ-001 SHALL have parameter ALARM_COUNT, default 3, giving the consecutive greater-than samples (1..15) that raise the alarm.
REQ-002 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset); one clock; reset is asynchronous and active-low.
REQ-003 SHALL have sign (in, 1): 0 = unsigned compare, 1 = two's-complement compare.
REQ-004 SHALL have thr_load (in, 1) and thr_data (in, 4), which load the threshold.
REQ-005 SHALL have in_valid (in, 1), in_data (in, 4) and in_ready (out, 1) as the sample handshake.
REQ-006 SHALL have out_valid (out, 1) and out_ready (in, 1) as the result handshake.
REQ-007 SHALL have equals, greater_than and less_than (out, 1 each), one-hot, giving in_data relative to the threshold.
REQ-008 SHALL have alarm (out, 1) and gt_count (out, 8), a saturating count of greater-than results.

Function
REQ-009 SHALL implement the FSM states IDLE (no threshold yet), RUN and ALARM.
REQ-010 SHALL take IDLE to RUN on thr_load, and SHALL hold in_ready = 0 while in IDLE.
REQ-011 SHALL define in_ready = (state != IDLE) && !thr_load && (!out_valid || out_ready).
REQ-012 SHALL treat a sample as accepted in any cycle with in_valid && in_ready.
REQ-013 SHALL compare an accepted sample against the current threshold using the sign value sampled in the same cycle.
REQ-014 SHALL register the result, with out_valid rising the cycle after acceptance (latency 1).
REQ-015 SHALL hold the result flags and out_valid stable until the cycle in which out_valid && out_ready.
REQ-016 SHALL clear out_valid on handshake unless a new sample is accepted in the same cycle, in which case it stays 1 with new flags (full throughput).
REQ-017 SHALL drive result flags to 0 whenever out_valid = 0.
REQ-018 SHALL keep a 4-bit run counter: +1 on an accepted greater-than, cleared on an accepted equal or less-than.
REQ-019 SHALL transition RUN to ALARM when the run counter reaches ALARM_COUNT, with alarm = 1 the same cycle out_valid presents that sample.
REQ-020 SHALL transition ALARM to RUN on an accepted non-greater sample, with alarm deasserting alongside that result.
REQ-021 SHALL increment gt_count on every accepted greater-than result, saturating at 255.
REQ-022 SHALL, on thr_load in RUN or ALARM: load the threshold, clear the run counter, clear alarm, enter RUN, and accept no sample that cycle.
REQ-023 SHALL NOT let thr_load alter a pending out_valid result.
REQ-024 SHALL ignore in_valid = 0 cycles, with no FSM or counter change.

Reset
REQ-025 SHALL, on rst_n low, immediately set: state IDLE, threshold 0, run counter 0, out_valid 0, flags 0, alarm 0, gt_count 0.
REQ-026 SHALL drop any pending result on reset mid-operation, leaving in_ready at 0 until a thr_load after reset release.

Configuration
REQ-027 SHALL, with CMP_MON_HYST_EN defined, require ALARM_COUNT consecutive accepted non-greater samples to leave ALARM.
REQ-028 SHALL, with CMP_MON_HYST_EN defined, make any greater-than sample in ALARM reset that exit count.
REQ-029 SHALL, without CMP_MON_HYST_EN, make the single-sample exit of REQ-020 apply.

Structure
REQ-030 SHALL place the FSM state enum, result-flag encoding and GT_COUNT_MAX = 255 in shared package cmp_pkg.
REQ-031 SHALL instantiate the compare as one combinational sub-module cmp_core (sign, a, b -> eq/gt/lt).

Verification
REQ-032 SHALL cover: in_valid = 1 with no thr_load -> in_ready = 0 and out_valid never rises.
REQ-033 SHALL cover: threshold 4'b0101, unsigned, sample 4'b1000 -> greater_than = 1 the next cycle, gt_count = 1.
REQ-034 SHALL cover: threshold 4'b0101, sign = 1, sample 4'b1000 (-8) -> less_than = 1.
REQ-035 SHALL cover: ALARM_COUNT = 3, samples 9, 9, 9 above threshold 5 -> alarm = 1 with the third result.
REQ-036 SHALL cover the following sample 2 -> alarm = 0 without CMP_MON_HYST_EN, and still 1 with it defined.
REQ-037 SHALL cover: out_ready = 0 for 4 cycles -> flags held and in_ready = 0, with no sample lost.
REQ-038 SHALL cover: 300 greater-than samples -> gt_count = 255.
REQ-039 SHALL cover: rst_n low mid-run -> all outputs 0 asynchronously.
